sram_mem_ctrl: RTL and testbench
================================

Name: sram_mem_ctrl

Overview:
- Memory-side responder for the load/store requests the execute stage issues: effective address from the ALU result, store data from the forwarded Rm value, and the MEM_R_EN/MEM_W_EN strobes.
- Turns each 32-bit word access into two 16-bit external SRAM half-word accesses.
- Drops ready while a transfer is in flight; the hazard/freeze logic uses ~ready to stall every pipeline stage.
- Sits in the MEM stage between the EX/MEM register and the external SRAM pins.

Parameters:
n, 32, CPU word width (fixed at 32; two SRAM halves)
SRAM_DW, 16, SRAM data bus width
SRAM_AW, 18, SRAM address width
BASE_ADDR, 1024, CPU byte address that maps to SRAM word 0
ACCESS_CYCLES, 3, clock cycles per half-word access; legal values 2..15

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
wr_en  in  1  store request (MEM_W_EN)
rd_en  in  1  load request (MEM_R_EN)
address  in  n  byte address (ALU result)
write_data  in  n  store data (Val_Rm)
read_data  out  n  load result, registered
ready  out  1  1 = no transfer pending or transfer completes this cycle; pipeline freeze = ~ready
sram_addr  out  SRAM_AW  half-word address to SRAM
sram_dq_out  out  SRAM_DW  data driven to SRAM
sram_dq_in  in  SRAM_DW  data returned by SRAM
sram_dq_oe  out  1  1 = controller drives the DQ bus
sram_we_n  out  1  active-low SRAM write strobe

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, cycle counter 0, read_data 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1.
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, computed modulo 2^n; bits [1:0] are ignored.
  - Low half: sram_addr = {word[SRAM_AW-2:0], 1'b0}. High half: the same with LSB 1.
  - Addresses below BASE_ADDR wrap; no error is raised.
- Request: req = rd_en | wr_en. If both are set, the access is treated as a write.
- Request hold rule: request and operands are sampled in IDLE and latched on entry to LOW. Upstream holds them stable while ready=0, which the freeze guarantees.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - ready = ~req (combinational).
  - On req, go to LOW, clear the counter, latch op/word/data.
- LOW and HIGH:
  - Each lasts exactly ACCESS_CYCLES cycles; the counter runs 0..ACCESS_CYCLES-1. Advance LOW→HIGH, then HIGH→DONE, when the counter reaches ACCESS_CYCLES-1.
  - Outputs are registered so they are valid throughout the state.
  - sram_addr is the half address for that state. ready = 0.
- Write in LOW/HIGH:
  - sram_dq_oe = 1 for the whole state.
  - sram_dq_out = write_data[15:0] in LOW, [31:16] in HIGH.
  - sram_we_n = 0 on every cycle except the last of each state, which gives a rising WE edge with data still held.
- Read in LOW/HIGH:
  - sram_dq_oe = 0, sram_we_n = 1.
  - sram_dq_in is captured on the last cycle of LOW into read_data[15:0], and of HIGH into read_data[31:16].
- DONE:
  - Lasts 1 cycle; ready = 1, sram_we_n = 1, sram_dq_oe = 0. Go to IDLE.
  - read_data holds the full word from DONE onward, until the next read's capture.
- Latency: request seen in IDLE at cycle T gives ready=1 at T+2*ACCESS_CYCLES+1 (T+7 at the default). Exactly one ready pulse per access.
- Back-to-back: a new request presented in the cycle after DONE starts in IDLE with no dead cycle beyond IDLE itself.
- Writes leave read_data unchanged.
- Reset mid-access: the transfer is aborted. All outputs reach their reset values at the next edge; no partial read_data update; sram_we_n = 1 immediately after that edge.

Decomposition:
- Shared package `arm_mem_pkg`:
  - state encoding typedef (IDLE/LOW/HIGH/DONE);
  - BASE_ADDR default constant;
  - SRAM width constants, also reused by the top-level pin wrapper and a future cache.
- Single module; no sub-module is warranted. The access counter is an inline 4-bit register.

Test Plan:
1. Reset: assert rst for 2 cycles during an active write → next cycle state IDLE, sram_we_n=1, sram_dq_oe=0, read_data=0, ready=1 with no request.
2. Write at address 1032 (BASE+8), data 0xDEADBEEF:
   - LOW: sram_addr=4, dq_out=0xBEEF, we_n=0,0,1.
   - HIGH: sram_addr=5, dq_out=0xDEAD, we_n=0,0,1.
   - ready=0 for 7 cycles, then 1 for exactly one cycle.
3. Read at address 1032 against a behavioural SRAM model preloaded by test 2 → read_data=0xDEADBEEF in the DONE cycle; sram_dq_oe=0 throughout; ready pulse at T+7.
4. Back-to-back: write 0x12345678 to 1024, then read 1024 presented immediately after DONE → second ready at exactly 7 cycles after its IDLE cycle; read_data=0x12345678.
5. rd_en=wr_en=1 at address 1028, data 0x0000FFFF → SRAM locations 2/3 written with 0xFFFF/0x0000; read_data unchanged.
6. Wrap: address 1020 (BASE-4) → sram_addr low/high = 0x3FFFE/0x3FFFF; idle with rd_en=wr_en=0 for 20 cycles → ready=1 and sram_we_n=1 constantly.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM path: FSM encoding, the SRAM window base
// and the external SRAM bus widths (also used by the pin wrapper and the cache).
package arm_mem_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_DONE} mem_state_t;

    localparam int ARM_BASE_ADDR = 1024;
    localparam int SRAM_DW_DEF   = 16;
    localparam int SRAM_AW_DEF   = 18;
endpackage

// File: rtl/sram_mem_ctrl.sv
// MEM-stage responder: splits each 32-bit load/store into two timed 16-bit SRAM accesses,
// dropping ready while the transfer is in flight so the pipeline freezes.
module sram_mem_ctrl
    import arm_mem_pkg::*;
#(
    parameter int n             = 32,
    parameter int SRAM_DW       = SRAM_DW_DEF,
    parameter int SRAM_AW       = SRAM_AW_DEF,
    parameter int BASE_ADDR     = ARM_BASE_ADDR,
    parameter int ACCESS_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [n-1:0]       address,
    input  logic [n-1:0]       write_data,
    output logic [n-1:0]       read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);
    localparam int          WW        = SRAM_AW - 1;
    localparam logic [n-1:0] L_BASE    = n'(BASE_ADDR);
    localparam logic [3:0]  L_LAST    = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0]  L_PRELAST = 4'(ACCESS_CYCLES - 2);

    mem_state_t        r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              r_wr;
    logic [WW-1:0]     r_word;
    logic [n-1:0]      r_data;
    logic [n-1:0]      r_read_data, w_read_data_nxt;
    logic [SRAM_AW-1:0] r_sram_addr, w_sram_addr_nxt;
    logic [SRAM_DW-1:0] r_dq_out, w_dq_out_nxt;
    logic              r_dq_oe, w_dq_oe_nxt;
    logic              r_we_n, w_we_n_nxt;
    logic              w_req, w_last, w_ready;
    logic [WW-1:0]     w_word;

    // Offset wraps modulo 2^n, so addresses below the base land at the top of SRAM.
    assign w_word = WW'((address - L_BASE) >> 2);
    assign w_req  = rd_en | wr_en;
    assign w_last = (r_cnt == L_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_read_data_nxt = r_read_data;
        w_sram_addr_nxt = r_sram_addr;
        w_dq_out_nxt    = r_dq_out;
        w_dq_oe_nxt     = r_dq_oe;
        w_we_n_nxt      = 1'b1;
        w_ready         = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_ready = ~w_req;
                if (w_req) begin
                    w_state_nxt     = ST_LOW;
                    w_cnt_nxt       = 4'd0;
                    w_sram_addr_nxt = {w_word, 1'b0};
                    w_dq_out_nxt    = write_data[SRAM_DW-1:0];
                    w_dq_oe_nxt     = wr_en;
                    w_we_n_nxt      = ~wr_en;
                end
            end
            ST_LOW, ST_HIGH: begin
                if (w_last) begin
                    w_cnt_nxt = 4'd0;
                    if (r_state == ST_LOW) begin
                        w_state_nxt     = ST_HIGH;
                        w_sram_addr_nxt = {r_word, 1'b1};
                        w_dq_out_nxt    = r_data[n-1:SRAM_DW];
                        w_dq_oe_nxt     = r_wr;
                        w_we_n_nxt      = ~r_wr;
                        if (!r_wr) w_read_data_nxt[SRAM_DW-1:0] = sram_dq_in;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_dq_oe_nxt = 1'b0;
                        if (!r_wr) w_read_data_nxt[n-1:SRAM_DW] = sram_dq_in;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                    // Release WE one cycle early so the rising edge sees stable data.
                    w_we_n_nxt = ~r_wr | (r_cnt == L_PRELAST);
                end
            end
            ST_DONE: begin
                w_ready     = 1'b1;
                w_state_nxt = ST_IDLE;
                w_dq_oe_nxt = 1'b0;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_wr        <= 1'b0;
            r_word      <= '0;
            r_data      <= '0;
            r_read_data <= '0;
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_read_data <= w_read_data_nxt;
            r_sram_addr <= w_sram_addr_nxt;
            r_dq_out    <= w_dq_out_nxt;
            r_dq_oe     <= w_dq_oe_nxt;
            r_we_n      <= w_we_n_nxt;
            if (r_state == ST_IDLE && w_req) begin
                r_wr   <= wr_en;
                r_word <= w_word;
                r_data <= write_data;
            end
        end
    end

    assign read_data   = r_read_data;
    assign ready       = w_ready;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_we_n   = r_we_n;
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: behavioural SRAM plus a word-level reference memory,
// directed cases followed by randomized load/store traffic.
module tb_sram_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:262143];
    logic [31:0] ref_mem [logic [16:0]];
    logic [31:0] rd_exp = '0;

    always #5 clk = ~clk;

    sram_mem_ctrl dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    // Asynchronous-read SRAM; a write lands while WE is low and the bus is driven.
    assign sram_dq_in = mem[sram_addr];
    always @(posedge clk) if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full access from the IDLE cycle through DONE, checking every cycle.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic [16:0] w;
        logic        hb;
        int          lat;
        w = 17'((a - 32'd1024) >> 2);
        if (wr) ref_mem[w] = d;
        else rd_exp = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        #1 chk("idle_busy", 32'(ready), 32'd0);
        lat = -1;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk); #1;
            if (j < 6) begin
                hb = (j >= 3);
                chk("xfer_ready", 32'(ready), 32'd0);
                chk("sram_addr", 32'(sram_addr), 32'({w, hb}));
                chk("dq_oe", 32'(sram_dq_oe), 32'(wr));
                chk("we_n", 32'(sram_we_n), wr ? 32'(j % 3 == 2) : 32'd1);
                if (wr) chk("dq_out", 32'(sram_dq_out), hb ? 32'(d[31:16]) : 32'(d[15:0]));
            end else if (ready) begin
                lat = j + 1;
                break;
            end
        end
        chk("latency", 32'(lat), 32'd7);
        chk("done_we_n", 32'(sram_we_n), 32'd1);
        chk("done_oe", 32'(sram_dq_oe), 32'd0);
        chk("read_data", read_data, rd_exp);
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
        #1 chk("idle_ready", 32'(ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_rdata", read_data, 32'd0);

        // Abort a write mid-flight (word 100 is never read back afterwards).
        wr_en = 1'b1; address = 32'd1424; write_data = 32'hAAAA5555;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_oe", 32'(sram_dq_oe), 32'd0);
        chk("abort_addr", 32'(sram_addr), 32'd0);
        chk("abort_dq", 32'(sram_dq_out), 32'd0);
        chk("abort_rdata", read_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0;
        #1 chk("post_rst_ready", 32'(ready), 32'd1);

        access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1032, $urandom);
        chk("rd_beef", read_data, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'd1024, 32'h12345678);
        access(1'b1, 1'b0, 32'd1024, 32'h0);
        chk("rd_b2b", read_data, 32'h12345678);
        access(1'b1, 1'b1, 32'd1028, 32'h0000FFFF);
        chk("mem2", 32'(mem[2]), 32'h0000FFFF);
        chk("mem3", 32'(mem[3]), 32'h0);
        chk("both_rdata", read_data, 32'h12345678);
        access(1'b0, 1'b1, 32'd1020, $urandom);
        access(1'b1, 1'b0, 32'd1020, 32'h0);

        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("quiet_ready", 32'(ready), 32'd1);
            chk("quiet_we_n", 32'(sram_we_n), 32'd1);
        end

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            bit r, wv;
            a = 32'd1024 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            r = 1'($urandom); wv = 1'($urandom);
            if (!r && !wv) r = 1'b1;
            access(r, wv, a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
